// File: rtl/lab5_mcore_adapter_pkg.sv
// Shared message formats and helpers for the tagged cache<->network adapter.
package lab5_mcore_adapter_pkg;

  localparam int c_net_srcdest_nbits = 2;
  localparam int c_mem_opaque_nbits  = 8;
  localparam int c_cacheline_nbytes  = 16;
  localparam int c_dest_addr_lsb     = $clog2(c_cacheline_nbytes);

  typedef struct packed {
    logic [2:0]                    type_;
    logic [c_mem_opaque_nbits-1:0] opaque;
    logic [31:0]                   addr;
    logic [3:0]                    len;
    logic [127:0]                  data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]                    type_;
    logic [c_mem_opaque_nbits-1:0] opaque;
    logic [1:0]                    test;
    logic [3:0]                    len;
    logic [127:0]                  data;
  } mem_resp_16B_t;

  typedef struct packed {
    logic [c_net_srcdest_nbits-1:0] dest;
    logic [c_net_srcdest_nbits-1:0] src;
    logic [c_mem_opaque_nbits-1:0]  opaque;
  } net_hdr_t;

  // Banks are interleaved on cache-line granularity.
  function automatic logic [c_net_srcdest_nbits-1:0] dest_from_addr(input logic [31:0] addr,
                                                                   input int num_banks);
    case (num_banks)
      2:       return {1'b0, addr[c_dest_addr_lsb]};
      4:       return addr[c_dest_addr_lsb +: 2];
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/lab5_mcore_tagged_upstream_adapter_tag_table.sv
// Outstanding-request table: valid bits, saved opaques, lowest-free allocator and occupancy count.
module lab5_mcore_adapter_tag_table #(
  parameter int p_num_tags   = 4,
  parameter int p_data_nbits = 8,
  localparam int c_tag_nbits = $clog2(p_num_tags)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_en_i,
  input  logic [p_data_nbits-1:0] alloc_data_i,
  input  logic                    free_en_i,
  input  logic [c_tag_nbits-1:0]  free_idx_i,
  input  logic [c_tag_nbits-1:0]  rd_idx_i,
  output logic [p_data_nbits-1:0] rd_data_o,
  output logic                    rd_valid_o,
  output logic [c_tag_nbits-1:0]  alloc_idx_o,
  output logic                    full_o,
  output logic [c_tag_nbits:0]    count_o
);

  logic [p_num_tags-1:0]   valid_q, valid_d;
  logic [p_data_nbits-1:0] data_q [p_num_tags];

  always_comb begin
    alloc_idx_o = '0;
    count_o     = '0;
    for (int i = p_num_tags - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx_o = c_tag_nbits'(i);
      count_o = count_o + (c_tag_nbits + 1)'(valid_q[i]);
    end
  end

  assign full_o     = (count_o == (c_tag_nbits + 1)'(p_num_tags));
  assign rd_data_o  = data_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

  // Free before alloc; alloc only picks an entry that is already clear, so they never collide.
  always_comb begin
    valid_d = valid_q;
    if (free_en_i)  valid_d[free_idx_i]  = 1'b0;
    if (alloc_en_i) valid_d[alloc_idx_o] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (alloc_en_i) data_q[alloc_idx_o] <= alloc_data_i;
  end

endmodule

// File: rtl/lab5_mcore_tagged_upstream_adapter.sv
// Cache-side adapter: swaps each request opaque for a local tag and restores it on the response.
module lab5_mcore_tagged_upstream_adapter
  import lab5_mcore_adapter_pkg::*;
#(
  parameter int p_num_banks = 1,
  parameter int p_num_tags  = 4,
  localparam int c_tag_nbits = $clog2(p_num_tags)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [c_net_srcdest_nbits-1:0] src_id,
  input  mem_req_16B_t                   memreq_msg,
  input  logic                           memreq_val,
  output logic                           memreq_rdy,
  output net_hdr_t                       netreq_msg_hdr,
  output mem_req_16B_t                   netreq_msg_payload,
  output logic                           netreq_val,
  input  logic                           netreq_rdy,
  input  net_hdr_t                       netresp_msg_hdr,
  input  mem_resp_16B_t                  netresp_msg_payload,
  input  logic                           netresp_val,
  output logic                           netresp_rdy,
  output mem_resp_16B_t                  memresp_msg,
  output logic                           memresp_val,
  input  logic                           memresp_rdy,
  output logic [c_tag_nbits:0]           num_outstanding,
  output logic                           err
);

  logic                          full, req_fire, resp_fire, resp_bad, upper_bad, rd_valid;
  logic [c_tag_nbits-1:0]        alloc_idx, resp_tag;
  logic [c_mem_opaque_nbits-1:0] rd_data;
  logic                          err_q, err_d;

  assign netreq_val  = memreq_val & ~full;
  assign memreq_rdy  = netreq_rdy & ~full;
  assign req_fire    = memreq_val & memreq_rdy;
  assign memresp_val = netresp_val;
  assign netresp_rdy = memresp_rdy;
  assign resp_fire   = netresp_val & memresp_rdy;

  assign resp_tag  = netresp_msg_payload.opaque[c_tag_nbits-1:0];
  assign upper_bad = |(netresp_msg_payload.opaque >> c_tag_nbits);
  assign resp_bad  = ~rd_valid | upper_bad | (netresp_msg_hdr.dest != src_id);

  lab5_mcore_adapter_tag_table #(
    .p_num_tags   (p_num_tags),
    .p_data_nbits (c_mem_opaque_nbits)
  ) u_tags (
    .clk          (clk),
    .reset        (reset),
    .alloc_en_i   (req_fire),
    .alloc_data_i (memreq_msg.opaque),
    .free_en_i    (resp_fire & ~resp_bad),
    .free_idx_i   (resp_tag),
    .rd_idx_i     (resp_tag),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .alloc_idx_o  (alloc_idx),
    .full_o       (full),
    .count_o      (num_outstanding)
  );

  always_comb begin
    netreq_msg_hdr            = '0;
    netreq_msg_hdr.dest       = dest_from_addr(memreq_msg.addr, p_num_banks);
    netreq_msg_hdr.src        = src_id;
    netreq_msg_payload        = memreq_msg;
    netreq_msg_payload.opaque = c_mem_opaque_nbits'(alloc_idx);
  end

  // Bad responses are still delivered so the cache never deadlocks, but with a neutral opaque.
  always_comb begin
    memresp_msg        = netresp_msg_payload;
    memresp_msg.opaque = resp_bad ? '0 : rd_data;
  end

  assign err_d = err_q | (resp_fire & resp_bad);
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign err = err_q;

endmodule
